crossbar_route_scheduler: RTL and testbench

Staged, glitch-free reconfiguration controller for the trigger crossbar switch matrix. Several requesters, such as the management APB bridge and a front-panel controller, write route changes into a shared shadow table through a round-robin arbiter. A commit then applies every pending change atomically. Changed outputs are blanked around the mux switch so no runt pulses reach the trigger outputs. The block drives the crossbar's `muxsel` array and a per-output blanking mask.

---
 rtl/crossbar_route_scheduler_pkg.sv | 36 +++
 rtl/crossbar_route_scheduler_arb.sv | 49 ++++
 rtl/crossbar_route_scheduler.sv | 174 +++++++++++++++++
 tb/tb_crossbar_route_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_route_scheduler_pkg.sv
// Shared types for the trigger crossbar route scheduler.
// Holds the mux selection type, the "output disconnected" code, the
// scheduler state enum, the staged-route request payload and a range helper.
package crossbar_route_scheduler_pkg;

  localparam int unsigned MUXSEL_W          = 4;
  localparam int unsigned PORT_W            = 4;
  localparam int unsigned NUM_PORTS_DEFAULT = 12;

  typedef logic [MUXSEL_W-1:0] muxsel_t;

  // A muxsel equal to the port count parks the output on nothing.
  localparam muxsel_t MUXSEL_OFF = muxsel_t'(NUM_PORTS_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_APPLY  = 2'd2,
    ST_SETTLE = 2'd3
  } sched_state_t;

  // Request payload of the currently granted requester.
  typedef struct packed {
    logic              commit;
    logic [PORT_W-1:0] port;
    muxsel_t           sel;
  } route_req_t;

  // Target must be a real output; source may be any input or MUXSEL_OFF.
  function automatic logic route_in_range(input logic [PORT_W-1:0] port,
                                          input muxsel_t           sel,
                                          input int unsigned       num_ports);
    return (32'(port) < num_ports) && (32'(sel) <= num_ports);
  endfunction

endpackage

// File: rtl/crossbar_route_scheduler_arb.sv
// Round-robin arbiter for the route scheduler request ports.
// Ports:
//   clk, rst_n : clock, async active-low reset (pointer resets to 0)
//   req        : N request lines
//   advance    : the granted request was taken; move pointer past winner
//   grant_c    : combinational one-hot grant, first request at/after pointer
module crossbar_route_scheduler_arb #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant_c
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_next_c;

  // Scan from the pointer, wrapping, and pick the first active request.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant_c    = '0;
    ptr_next_c = ptr_q;
    found      = 1'b0;
    idx        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[PW'(idx)]) begin
        found            = 1'b1;
        grant_c[PW'(idx)] = 1'b1;
        ptr_next_c       = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_next_c;
    end
  end

endmodule

// File: rtl/crossbar_route_scheduler.sv
// Staged, glitch-free reconfiguration controller for the trigger crossbar.
// Requesters stage route writes into a shadow table through a round-robin
// arbiter; a commit applies all pending changes atomically, blanking only the
// outputs that change for BLANK_CYCLES before and after the mux switch.
// Optional build macro: CROSSBAR_SCHED_LOCK_EN -- first valid stager owns the
// shadow table until its commit completes; others get error responses.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   req_valid/req_ready     : per-requester handshake (req_ready combinational)
//   req_commit              : 1 = commit, 0 = stage write
//   req_port/req_sel        : stage write target output / source input
//   resp_valid/resp_err     : one-cycle completion pulse and error flag
//   muxsel                  : live crossbar selection per output
//   blank                   : per-output force-low mask
//   busy                    : commit in progress
module crossbar_route_scheduler
  import crossbar_route_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 12,
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_commit,
  input  logic [NUM_REQ-1:0][PORT_W-1:0]   req_port,
  input  muxsel_t [NUM_REQ-1:0]            req_sel,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [NUM_REQ-1:0]               resp_err,
  output muxsel_t [NUM_PORTS-1:0]          muxsel,
  output logic [NUM_PORTS-1:0]             blank,
  output logic                             busy
);

  localparam int unsigned RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(BLANK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLANK_CYCLES - 1);

  sched_state_t             state_q, state_d;
  logic [CW-1:0]            cnt_q;
  muxsel_t [NUM_PORTS-1:0]  shadow_q;
  logic [RW-1:0]            cmt_q;

  logic [NUM_REQ-1:0]       grant_c;
  logic [RW-1:0]            win_c;
  route_req_t               wreq_c;
  logic [NUM_PORTS-1:0]     changed_c;
  logic                     accept_c, range_ok_c, foreign_c;
  logic                     do_stage_c, do_commit_c, start_c, stage_err_c, done_c;

  crossbar_route_scheduler_arb #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept_c),
    .grant_c (grant_c)
  );

  // Requests are only taken while idle; ready stays low throughout reset.
  assign accept_c  = (state_q == ST_IDLE) && (|grant_c);
  assign req_ready = (rst_n && (state_q == ST_IDLE)) ? grant_c : '0;

  // Select the granted requester's payload.
  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) win_c = RW'(i);
    end
    wreq_c.commit = req_commit[win_c];
    wreq_c.port   = req_port[win_c];
    wreq_c.sel    = req_sel[win_c];
  end

  always_comb begin
    changed_c = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      changed_c[i] = (shadow_q[i] != muxsel[i]);
    end
  end

`ifdef CROSSBAR_SCHED_LOCK_EN
  logic          lock_q;
  logic [RW-1:0] owner_q;

  assign foreign_c = lock_q && (owner_q != win_c);

  // Ownership taken by the first good stage, dropped at commit response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else if (done_c || (do_commit_c && !start_c)) begin
      lock_q  <= 1'b0;
    end else if (do_stage_c && !lock_q) begin
      lock_q  <= 1'b1;
      owner_q <= win_c;
    end
  end
`else
  assign foreign_c = 1'b0;
`endif

  assign range_ok_c  = route_in_range(wreq_c.port, wreq_c.sel, NUM_PORTS);
  assign do_stage_c  = accept_c && !wreq_c.commit && range_ok_c && !foreign_c;
  assign do_commit_c = accept_c && wreq_c.commit && !foreign_c;
  assign start_c     = do_commit_c && (|changed_c);
  assign stage_err_c = foreign_c || (!wreq_c.commit && !range_ok_c);
  assign done_c      = (state_q == ST_SETTLE) && (state_d == ST_IDLE);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_c) state_d = ST_BLANK;
      ST_BLANK:  if (cnt_q == CNT_LAST) state_d = ST_APPLY;
      ST_APPLY:  state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, counter, shadow table and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shadow_q   <= '0;
      cmt_q      <= '0;
      muxsel     <= '0;
      blank      <= '0;
      busy       <= 1'b0;
      resp_valid <= '0;
      resp_err   <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != ST_IDLE);
      resp_valid <= '0;
      resp_err   <= '0;

      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if ((state_q == ST_BLANK) || (state_q == ST_SETTLE)) begin
        cnt_q <= cnt_q + CW'(1);
      end

      // Stage writes, no-op commits and rejected requests answer next cycle.
      if (accept_c && !start_c) begin
        resp_valid[win_c] <= 1'b1;
        resp_err[win_c]   <= stage_err_c;
      end

      if (do_stage_c) begin
        shadow_q[wreq_c.port] <= wreq_c.sel;
      end

      if (start_c) begin
        cmt_q <= win_c;
        blank <= changed_c;
      end

      if (state_q == ST_APPLY) begin
        muxsel <= shadow_q;
      end

      if (done_c) begin
        blank             <= '0;
        resp_valid[cmt_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crossbar_route_scheduler.sv
// Self-checking bench for crossbar_route_scheduler: reset values, arbitration,
// table-driven stage writes, commit timing, no-op commit, reset mid-commit,
// optional lock behaviour and randomized traffic against a route-table model.
module tb_crossbar_route_scheduler;

  localparam int NP = 12;
  localparam int NR = 2;
  localparam int B  = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NR-1:0]         req_valid, req_ready, req_commit, resp_valid, resp_err;
  logic [NR-1:0][3:0]    req_port, req_sel;
  logic [NP-1:0][3:0]    muxsel;
  logic [NP-1:0]         blank;
  logic                  busy;

  always #5 clk = ~clk;

  crossbar_route_scheduler #(
    .NUM_PORTS(NP), .NUM_REQ(NR), .BLANK_CYCLES(B)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_commit(req_commit),
    .req_port(req_port), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .muxsel(muxsel), .blank(blank), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Route-table model: live selection, staged selection, arbitration pointer.
  int m_mux[NP];
  int m_shadow[NP];
  int m_ptr;
`ifdef CROSSBAR_SCHED_LOCK_EN
  int m_owner;
`endif

  typedef struct {
    int r;
    int port;
    int sel;
    bit exp_err;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mux_exp();
    logic [63:0] v = '0;
    for (int i = 0; i < NP; i++) v[i*4 +: 4] = 4'(m_mux[i]);
    return v;
  endfunction

  function automatic logic [63:0] shadow_exp();
    logic [63:0] v = '0;
    for (int i = 0; i < NP; i++) v[i*4 +: 4] = 4'(m_shadow[i]);
    return v;
  endfunction

  function automatic bit model_err(input int r, input int port, input int sel);
    bit e = (port >= NP) || (sel > NP);
`ifdef CROSSBAR_SCHED_LOCK_EN
    if (m_owner >= 0 && m_owner != r) e = 1'b1;
`else
    if (r < 0) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_mux[i]    = 0;
      m_shadow[i] = 0;
    end
    m_ptr = 0;
`ifdef CROSSBAR_SCHED_LOCK_EN
    m_owner = -1;
`endif
  endtask

  // Present one request from requester r; returns once at T+1 (+1ns).
  task automatic accept_req(input int r, input bit commit, input int port,
                            input int sel, output bit ok);
    int n = 0;
    req_valid     = '0;
    req_valid[r]  = 1'b1;
    req_commit[r] = commit;
    req_port[r]   = 4'(port);
    req_sel[r]    = 4'(sel);
    #1;
    while (!req_ready[r] && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("grant", 64'(req_ready), 64'(1 << r));
    ok = req_ready[r];
    if (ok) begin
      @(posedge clk); #1;
      m_ptr = (r + 1) % NR;
    end
    req_valid = '0;
  endtask

  task automatic stage(input int r, input int port, input int sel, input bit exp_err);
    bit ok;
    accept_req(r, 1'b0, port, sel, ok);
    if (!ok) return;
    chk("stage_resp_valid", 64'(resp_valid), 64'(1 << r));
    chk("stage_resp_err", 64'(resp_err), exp_err ? 64'(1 << r) : 64'd0);
    chk("stage_muxsel_untouched", 64'(muxsel), mux_exp());
    chk("stage_blank_busy", 64'({blank, busy}), 64'd0);
    if (!exp_err) begin
      m_shadow[port] = sel;
`ifdef CROSSBAR_SCHED_LOCK_EN
      if (m_owner < 0) m_owner = r;
`endif
    end
  endtask

  // Commit from requester r; abort_k>0 returns at sample T+abort_k unchecked.
  task automatic commit(input int r, input int abort_k);
    logic [NP-1:0] chg;
    logic [63:0]   old_m, new_m;
    bit            foreign = 1'b0;
    bit            ok;
    for (int i = 0; i < NP; i++) chg[i] = (m_shadow[i] != m_mux[i]);
`ifdef CROSSBAR_SCHED_LOCK_EN
    foreign = (m_owner >= 0) && (m_owner != r);
`endif
    old_m = mux_exp();
    new_m = shadow_exp();
    accept_req(r, 1'b1, 0, 0, ok);
    if (!ok) return;
    if (foreign || chg == '0) begin
      chk("short_commit_resp_valid", 64'(resp_valid), 64'(1 << r));
      chk("short_commit_resp_err", 64'(resp_err), foreign ? 64'(1 << r) : 64'd0);
      chk("short_commit_blank_busy", 64'({blank, busy}), 64'd0);
      chk("short_commit_muxsel", 64'(muxsel), old_m);
`ifdef CROSSBAR_SCHED_LOCK_EN
      if (!foreign) m_owner = -1;
`endif
      return;
    end
    for (int k = 1; k <= 2*B + 1; k++) begin
      if (k == abort_k) return;
      chk("commit_blank", 64'(blank), 64'(chg));
      chk("commit_busy", 64'(busy), 64'd1);
      chk("commit_no_resp", 64'(resp_valid), 64'd0);
      chk("commit_muxsel", 64'(muxsel), (k >= B + 2) ? new_m : old_m);
      @(posedge clk); #1;
    end
    chk("commit_done_resp_valid", 64'(resp_valid), 64'(1 << r));
    chk("commit_done_resp_err", 64'(resp_err), 64'd0);
    chk("commit_done_blank_busy", 64'({blank, busy}), 64'd0);
    chk("commit_done_muxsel", 64'(muxsel), new_m);
    for (int i = 0; i < NP; i++) m_mux[i] = m_shadow[i];
`ifdef CROSSBAR_SCHED_LOCK_EN
    m_owner = -1;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] exp_g[4];
    logic [NR-1:0] got_g;
    int            w;
    bit            saw_resp;

    tbl[0] = '{r: 0, port: 3,  sel: 7,  exp_err: 1'b0};
    tbl[1] = '{r: 0, port: 12, sel: 1,  exp_err: 1'b1};
    tbl[2] = '{r: 0, port: 0,  sel: 13, exp_err: 1'b1};
    tbl[3] = '{r: 0, port: 5,  sel: 12, exp_err: 1'b0};
    tbl[4] = '{r: 0, port: 15, sel: 15, exp_err: 1'b1};
    tbl[5] = '{r: 0, port: 11, sel: 0,  exp_err: 1'b0};
    tbl[6] = '{r: 0, port: 10, sel: 9,  exp_err: 1'b0};
    tbl[7] = '{r: 0, port: 3,  sel: 13, exp_err: 1'b1};
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;

    // Reset values, with both requesters asserting valid.
    model_reset();
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_commit = '0;
    req_port   = '0;
    req_sel    = '0;
    #3;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_muxsel", 64'(muxsel), 64'd0);
    chk("reset_blank_busy", 64'({blank, busy}), 64'd0);
    chk("reset_resp", 64'({resp_valid, resp_err}), 64'd0);
    req_valid = '0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arbitration: both valid for four cycles starting with pointer 0.
    req_commit  = '0;
    req_port[0] = 4'd1; req_sel[0] = 4'd2;
    req_port[1] = 4'd2; req_sel[1] = 4'd5;
    req_valid   = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      got_g = req_ready;
      chk("arb_grant_order", 64'(got_g), 64'(exp_g[i]));
      w = (got_g == 2'b10) ? 1 : 0;
      @(posedge clk); #1;
      if (i == 3) req_valid = '0;
      chk("arb_resp_valid", 64'(resp_valid), 64'(1 << w));
      chk("arb_resp_err", 64'(resp_err), 64'd0);
      m_shadow[(w == 0) ? 1 : 2] = (w == 0) ? 2 : 5;
      m_ptr = (w + 1) % NR;
    end
    commit(0, 0);

    // Stage port 3 = 7 then commit: only port 3 blanks.
    stage(tbl[0].r, tbl[0].port, tbl[0].sel, tbl[0].exp_err);
    commit(0, 0);
    chk("port3_routed", 64'(muxsel[3]), 64'd7);

    // Range errors and boundary values from the table.
    for (int i = 1; i < 8; i++) begin
      stage(tbl[i].r, tbl[i].port, tbl[i].sel, tbl[i].exp_err);
    end
    commit(1, 0);
    chk("off_code_routed", 64'(muxsel[5]), 64'd12);
    chk("port3_kept", 64'(muxsel[3]), 64'd7);

    // No-op commit: shadow already matches live selection.
    commit(0, 0);

`ifdef CROSSBAR_SCHED_LOCK_EN
    // Ownership: req0 locks, req1 is refused until req0's commit completes.
    stage(0, 6, 1, 1'b0);
    stage(1, 7, 2, 1'b1);
    commit(1, 0);
    commit(0, 0);
    stage(1, 7, 2, 1'b0);
    commit(1, 0);
`endif

    // Reset during SETTLE: immediate clear, no late response.
    stage(0, 4, (m_mux[4] + 1) % NP, 1'b0);
    commit(0, B + 5);
    #2;
    rst_n        = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    chk("midreset_muxsel", 64'(muxsel), 64'd0);
    chk("midreset_blank_busy", 64'({blank, busy}), 64'd0);
    chk("midreset_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #3;
    rst_n    = 1'b1;
    saw_resp = 1'b0;
    for (int k = 0; k < 2*B + 4; k++) begin
      @(posedge clk); #1;
      if (resp_valid != '0) saw_resp = 1'b1;
    end
    chk("midreset_no_response", 64'(saw_resp), 64'd0);
    chk("midreset_muxsel_after", 64'(muxsel), 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      int r, port, sel;
      r = int'($urandom_range(0, NR - 1));
      if ($urandom_range(0, 4) == 0) begin
        commit(r, 0);
      end else begin
        port = int'($urandom_range(0, 15));
        sel  = int'($urandom_range(0, 15));
        stage(r, port, sel, model_err(r, port, sel));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
`ifdef CROSSBAR_SCHED_LOCK_EN
    commit((m_owner >= 0) ? m_owner : 0, 0);
`else
    commit(0, 0);
`endif
    chk("final_muxsel", 64'(muxsel), mux_exp());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
